joysplitter_scheduler: RTL and testbench

Time-multiplexes the single DB9 joystick port between two physical joysticks attached through a hardware splitter. It drives the splitter select line, waits a settle window after each switch, then samples and debounces the port. It presents two clean, independent joystick states to the joystick protocol decoder. When the splitter is disabled, it passes joystick 1 only, using the same sampling and debounce path.

---
 rtl/joysplitter_scheduler_if.sv | 11 +
 rtl/joysplitter_scheduler.sv | 64 ++++++
 tb/tb_joysplitter_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/joysplitter_scheduler_if.sv
// joysplitter_scheduler_if: joystick port bundle between the splitter scheduler and its host
interface joysplitter_scheduler_if;
  logic       enable;
  logic [5:0] db9_in;
  logic       joy_sel;
  logic [5:0] joy1_out;
  logic [5:0] joy2_out;
  logic       sample_strobe;
  modport master (output enable, db9_in, input joy_sel, joy1_out, joy2_out, sample_strobe);
  modport slave (input enable, db9_in, output joy_sel, joy1_out, joy2_out, sample_strobe);
endinterface

// File: rtl/joysplitter_scheduler.sv
// joysplitter_scheduler: time-multiplexes one DB9 port between two joysticks with settle, sample and debounce
module joysplitter_scheduler #(
  parameter int PERIOD = 28000,
  parameter int SETTLE = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  joysplitter_scheduler_if.slave  bus
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [5:0] IDLE = 6'h3F;
  typedef enum logic [1:0] {S_SETTLE, S_SAMPLE, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic slot_q, slot_d;
  logic [5:0] sync1_q, sync2_q;
  logic [5:0] prev0_q, prev0_d, prev1_q, prev1_d;
  logic [5:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic strobe_q, strobe_d;
  logic abort, wrap, smp;
  assign bus.joy_sel = slot_q;
  assign bus.joy1_out = joy1_q;
  assign bus.joy2_out = joy2_q;
  assign bus.sample_strobe = strobe_q;
  // two-flop synchronizer for the asynchronous DB9 lines
  always_ff @(posedge clk or posedge rst)
    if (rst) {sync2_q, sync1_q} <= {IDLE, IDLE};
    else {sync2_q, sync1_q} <= {sync1_q, bus.db9_in};
  // slot phase, counter and debounce registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_SETTLE;
      cnt_q <= '0;
      slot_q <= 1'b0;
      prev0_q <= IDLE;
      prev1_q <= IDLE;
      joy1_q <= IDLE;
      joy2_q <= IDLE;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      prev0_q <= prev0_d;
      prev1_q <= prev1_d;
      joy1_q <= joy1_d;
      joy2_q <= joy2_d;
      strobe_q <= strobe_d;
    end
  // disabling while on joystick 2 restarts slot 0 at once and drops any pending sample
  always_comb begin
    abort = !bus.enable && slot_q;
    wrap = cnt_q == CW'(PERIOD - 1);
    smp = (state_q == S_SAMPLE) && !abort;
    cnt_d = (abort || wrap) ? '0 : cnt_q + CW'(1);
    slot_d = abort ? 1'b0 : wrap ? (bus.enable && !slot_q) : slot_q;
    state_d = (cnt_d < CW'(SETTLE)) ? S_SETTLE : (cnt_d == CW'(SETTLE)) ? S_SAMPLE : S_HOLD;
    prev0_d = (smp && !slot_q) ? sync2_q : prev0_q;
    prev1_d = !bus.enable ? IDLE : (smp && slot_q) ? sync2_q : prev1_q;
    joy1_d = (smp && !slot_q && sync2_q == prev0_q) ? sync2_q : joy1_q;
    joy2_d = !bus.enable ? IDLE : (smp && slot_q && sync2_q == prev1_q) ? sync2_q : joy2_q;
    strobe_d = smp;
  end
endmodule

// File: tb/tb_joysplitter_scheduler.sv
// tb_joysplitter_scheduler: slot-level scoreboard bench for the joystick splitter scheduler
module tb_joysplitter_scheduler;
  localparam int PERIOD = 16;
  localparam int SETTLE = 4;
  localparam logic [5:0] IDLE = 6'h3F;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [5:0] bprev [2];
  logic [5:0] bout [2];
  logic [5:0] cur1, cur2;
  bit bslot;
  logic [11:0] q [$];
  joysplitter_scheduler_if bus();
  joysplitter_scheduler #(.PERIOD(PERIOD), .SETTLE(SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit exp_stb);
    @(posedge clk);
    #1;
    chk("strobe", {5'b0, bus.sample_strobe}, {5'b0, exp_stb});
    if (bus.sample_strobe === 1'b1) begin
      chk("sb_avail", {5'b0, q.size() != 0}, 6'd1);
      if (q.size() != 0) {cur1, cur2} = q.pop_front();
    end
    chk("joy1", bus.joy1_out, cur1);
    chk("joy2", bus.joy2_out, cur2);
  endtask
  task automatic model_reset();
    bprev = '{IDLE, IDLE};
    bout = '{IDLE, IDLE};
    cur1 = IDLE;
    cur2 = IDLE;
    bslot = 1'b0;
    q.delete();
  endtask
  task automatic run_slot(input logic [5:0] v0, input logic [5:0] v1, input bit glitch, input int cut);
    logic [5:0] v;
    bit nxt;
    v = bslot ? v1 : v0;
    nxt = bus.enable ? !bslot : 1'b0;
    if (v === bprev[bslot]) bout[bslot] = v;
    bprev[bslot] = v;
    q.push_back({bout[0], bout[1]});
    for (int i = 1; i <= PERIOD; i++) begin
      if (i - 1 == cut) begin
        bus.enable = 1'b0;
        bslot = 1'b0;
        bprev[1] = IDLE;
        bout[1] = IDLE;
        cur2 = IDLE;
        tick(1'b0);
        chk("sel_dis", {5'b0, bus.joy_sel}, 6'd0);
        return;
      end
      bus.db9_in = (glitch && i <= 2) ? 6'h00 : v;
      tick(i == SETTLE + 1);
      chk("sel", {5'b0, bus.joy_sel}, {5'b0, (i == PERIOD) ? nxt : bslot});
    end
    bslot = nxt;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [5:0] bv [8];
    bv = '{6'h3F, 6'h3F, 6'h3E, 6'h3F, 6'h3E, 6'h3F, 6'h3E, 6'h3E};
    model_reset();
    bus.enable = 1'b0;
    bus.db9_in = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", {5'b0, bus.joy_sel}, 6'd0);
    chk("rst_joy1", bus.joy1_out, IDLE);
    chk("rst_joy2", bus.joy2_out, IDLE);
    chk("rst_stb", {5'b0, bus.sample_strobe}, 6'd0);
    rst = 1'b0;
    repeat (3) run_slot(6'h2F, 6'h2F, 1'b0, -1);
    bus.enable = 1'b1;
    repeat (6) run_slot(6'h3E, 6'h3D, 1'b0, -1);
    repeat (4) run_slot(6'h3E, 6'h3D, 1'b1, -1);
    for (int k = 0; k < 8; k++) begin
      run_slot(bv[k], 6'h3D, 1'b0, -1);
      run_slot(bv[k], 6'h3D, 1'b0, -1);
    end
    run_slot(6'h3E, 6'h3D, 1'b0, -1);
    run_slot(6'h3E, 6'h3D, 1'b0, 7);
    repeat (2) run_slot(6'h2F, 6'h3D, 1'b0, -1);
    repeat (3) tick(1'b0);
    #3;
    bus.db9_in = 6'h00;
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", {5'b0, bus.joy_sel}, 6'd0);
    chk("mid_rst_joy1", bus.joy1_out, IDLE);
    chk("mid_rst_joy2", bus.joy2_out, IDLE);
    chk("mid_rst_stb", {5'b0, bus.sample_strobe}, 6'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.enable = 1'b1;
    repeat (4) run_slot(6'h2F, 6'h1F, 1'b0, -1);
    chk("sb_left", 6'(q.size()), 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
